axi_slave_mem_sched: RTL and testbench

Sequences one AXI4 slave port onto a single-port word SRAM. The SRAM is always ready, has 1-cycle read latency, and performs one access per cycle. The block arbitrates AW vs AR round-robin, runs one burst at a time, generates beat addresses, and returns B and R responses. It sits between the interconnect slave port of ppu_top and a local memory bank.

---
 rtl/axi_sched_pkg.sv | 36 +++
 rtl/axi_sched_rfifo.sv | 38 +++
 rtl/axi_slave_mem_sched.sv | 208 ++++++++++++++++++++
 tb/tb_axi_slave_mem_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI slave to SRAM scheduler.
package axi_sched_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned CNT_W   = LEN_W + 1;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'd0;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'd1;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'd2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } rd_entry_t;

  // Only full-word beats with FIXED or INCR bursts are served without error.
  function automatic logic cmd_err(input logic [2:0] size, input logic [BURST_W-1:0] burst);
    return (size != 3'd2) || (burst >= BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_sched_rfifo.sv
// Two-entry read-beat FIFO; supports push and pop in the same cycle.
module axi_sched_rfifo
  import axi_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rd_entry_t  push_data,
  input  logic       pop,
  output rd_entry_t  head,
  output logic [1:0] count
);

  rd_entry_t slots [2];
  logic      wr_ptr;
  logic      rd_ptr;

  // Pointer and occupancy tracking, flushed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/axi_slave_mem_sched.sv
// Serialises one AXI4 slave port onto a single-port, 1-cycle-latency word SRAM.
module axi_slave_mem_sched
  import axi_sched_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [31:0]               aw_addr,
  input  logic [7:0]                aw_len,
  input  logic [2:0]                aw_size,
  input  logic [1:0]                aw_burst,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] w_data,
  input  logic [3:0]                w_strb,
  input  logic                      w_last,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output logic [1:0]                b_resp,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  input  logic [31:0]               ar_addr,
  input  logic [7:0]                ar_len,
  input  logic [2:0]                ar_size,
  input  logic [1:0]                ar_burst,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [AXI_DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]                mem_be,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata
);

  state_t                    state;
  state_t                    state_n;
  logic                      prefer_r;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [LEN_W-1:0]          len;
  logic [CNT_W-1:0]          cnt;
  logic [AXI_ID_WIDTH-1:0]   id;
  logic [BURST_W-1:0]        burst;
  logic                      err;
  logic                      rd_pend;
  logic                      pend_last;

  logic      grant_w, grant_r;
  logic      aw_hs, ar_hs, w_beat;
  logic      last_beat, rd_left, rd_room, issue, pop;
  rd_entry_t push_data, head;
  logic [1:0] fifo_count;
  logic      unused_addr_bits;

  // Word-address slice only; byte offset and out-of-range bits alias away.
  assign unused_addr_bits = ^{aw_addr[31:MEM_ADDR_WIDTH+2], aw_addr[1:0],
                              ar_addr[31:MEM_ADDR_WIDTH+2], ar_addr[1:0]};

  assign grant_w   = aw_valid && (!ar_valid || !prefer_r);
  assign grant_r   = ar_valid && (!aw_valid ||  prefer_r);
  assign aw_hs     = aw_valid && aw_ready;
  assign ar_hs     = ar_valid && ar_ready;
  assign w_beat    = w_valid && w_ready;
  assign last_beat = (cnt == {1'b0, len});
  assign rd_left   = (cnt <= {1'b0, len});
  assign pop       = r_valid && r_ready;
  // A slot freed by this cycle's pop may be refilled, keeping one beat per cycle.
  assign rd_room   = (3'(fifo_count) + 3'(rd_pend)) < (3'd2 + 3'(pop));

  assign push_data = '{data: err ? '0 : mem_rdata,
                       resp: err ? RESP_SLVERR : RESP_OKAY,
                       last: pend_last};

  axi_sched_rfifo u_rfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign r_valid = !rst && (fifo_count != 2'd0);
  assign r_data  = r_valid ? head.data : '0;
  assign r_resp  = r_valid ? head.resp : '0;
  assign r_last  = r_valid && head.last;
  assign r_id    = r_valid ? id : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake/SRAM strobes; everything forced low during reset.
  always_comb begin
    state_n   = state;
    aw_ready  = 1'b0;
    ar_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_id      = '0;
    b_resp    = RESP_OKAY;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        aw_ready = grant_w;
        ar_ready = grant_r;
        if (grant_w)      state_n = ST_WRITE;
        else if (grant_r) state_n = ST_READ;
      end
      ST_WRITE: begin
        w_ready  = 1'b1;
        mem_addr = addr;
        if (w_valid) begin
          mem_req   = !err;
          mem_we    = 1'b1;
          mem_be    = w_strb;
          mem_wdata = w_data;
          if (last_beat) state_n = ST_WRESP;
        end
      end
      ST_WRESP: begin
        b_valid = 1'b1;
        b_id    = id;
        b_resp  = err ? RESP_SLVERR : RESP_OKAY;
        if (b_ready) state_n = ST_IDLE;
      end
      ST_READ: begin
        mem_addr = addr;
        if (rd_left && rd_room) begin
          issue   = 1'b1;
          mem_req = !err;
        end
        if (pop && head.last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) begin
      aw_ready = 1'b0;
      ar_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      b_id     = '0;
      b_resp   = RESP_OKAY;
      mem_req  = 1'b0;
      issue    = 1'b0;
    end
  end

  // Burst context: command latch, beat counter, address stepping, arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_r  <= 1'b1;
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      id        <= '0;
      burst     <= BURST_FIXED;
      err       <= 1'b0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (state == ST_IDLE && aw_valid && ar_valid) prefer_r <= !prefer_r;
      if (aw_hs) begin
        addr  <= aw_addr[MEM_ADDR_WIDTH+1:2];
        len   <= aw_len;
        id    <= aw_id;
        burst <= aw_burst;
        err   <= cmd_err(aw_size, aw_burst);
        cnt   <= '0;
      end else if (ar_hs) begin
        addr  <= ar_addr[MEM_ADDR_WIDTH+1:2];
        len   <= ar_len;
        id    <= ar_id;
        burst <= ar_burst;
        err   <= cmd_err(ar_size, ar_burst);
        cnt   <= '0;
      end
      if (w_beat || issue) begin
        cnt <= cnt + CNT_W'(1);
        if (burst == BURST_INCR) addr <= addr + MEM_ADDR_WIDTH'(1);
      end
      if (w_beat && (w_last != last_beat)) err <= 1'b1;
      if (issue) pend_last <= last_beat;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_sched.sv
// Directed bench for axi_slave_mem_sched with a behavioural SRAM.
module tb_axi_slave_mem_sched;
  import axi_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_id;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_id;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  axi_slave_mem_sched dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM plus write log and activity counters.
  logic [31:0] sram        [0:4095];
  logic [11:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int wr_n = 0, memreq_n = 0, whs_n = 0, both_viol = 0;

  always @(posedge clk) begin
    if (mem_req) begin
      memreq_n <= memreq_n + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (wr_n < 64) begin
          wr_addr_log[wr_n] <= mem_addr;
          wr_data_log[wr_n] <= mem_wdata;
        end
        wr_n <= wr_n + 1;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
    if (w_valid && w_ready) whs_n <= whs_n + 1;
  end

  always @(negedge clk) if (aw_ready && ar_ready) both_viol <= both_viol + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Read capture
  logic [31:0] rd_data [0:15];
  logic [1:0]  rd_resp [0:15];
  logic        rd_last [0:15];
  int          rd_cyc  [0:15];
  logic [3:0]  rd_id0;
  int rd_n, hs_cyc, first_cyc, hold_bad;

  // All tasks start and end at posedge+1.
  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] i);
    int t = 0;
    aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_id = i; aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && t < 20) begin @(negedge clk); t++; end
    check_eq("aw_accept", 32'(t < 20), 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [3:0] i);
    int t = 0;
    ar_addr = a; ar_len = l; ar_size = 3'd2; ar_burst = b; ar_id = i; ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && t < 20) begin @(negedge clk); t++; end
    check_eq("ar_accept", 32'(t < 20), 32'd1);
    @(posedge clk); #1;
    hs_cyc = cyc;
    ar_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [3:0] i, input logic [31:0] base, input int bad,
                          output logic [3:0] bid, output logic [1:0] bresp);
    int t;
    send_aw(a, l, s, BURST_INCR, i);
    for (int k = 0; k <= int'(l); k++) begin
      t = 0;
      w_valid = 1'b1; w_data = base + 32'(k); w_strb = 4'hF;
      w_last = (bad < 0) ? (k == int'(l)) : (k == bad);
      @(negedge clk);
      while (!w_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) check_eq("w_accept_timeout", 32'(t), 32'd0);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_valid && t < 20) begin @(negedge clk); t++; end
    check_eq("b_wait", 32'(t < 20), 32'd1);
    bid = b_id; bresp = b_resp;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] i, input bit stall);
    logic [3:0]  pat = 4'b1001;
    logic [31:0] held = '0;
    bit held_v = 1'b0, done = 1'b0;
    rd_n = 0; first_cyc = -1; hold_bad = 0;
    send_ar(a, l, b, i);
    for (int k = 0; k < 60; k++) begin
      r_ready = stall ? pat[2'(k % 4)] : 1'b1;
      @(negedge clk);
      if (r_valid) begin
        if (first_cyc < 0) begin first_cyc = cyc; rd_id0 = r_id; end
        if (held_v && r_data !== held) hold_bad++;
        if (r_ready) begin
          if (rd_n < 16) begin
            rd_data[rd_n] = r_data; rd_resp[rd_n] = r_resp;
            rd_last[rd_n] = r_last; rd_cyc[rd_n] = cyc;
          end
          rd_n++;
          held_v = 1'b0;
          if (r_last) done = 1'b1;
        end else begin
          held = r_data; held_v = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (done) break;
    end
    r_ready = 1'b0;
    check_eq("r_done", 32'(done), 32'd1);
  endtask

  initial begin
    logic [3:0] bid;
    logic [1:0] bresp;
    int wb, mb, hb, bv0, g;
    int grant [0:3];

    rst = 1'b1;
    aw_valid = 1'b1; aw_addr = '0; aw_len = '0; aw_size = 3'd2; aw_burst = BURST_INCR; aw_id = '0;
    ar_valid = 1'b1; ar_addr = '0; ar_len = '0; ar_size = 3'd2; ar_burst = BURST_INCR; ar_id = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
    b_ready = 1'b0; r_ready = 1'b0;

    // Reset: outputs quiet even with both address channels requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_aw_ready", 32'(aw_ready), 32'd0);
    check_eq("rst_ar_ready", 32'(ar_ready), 32'd0);
    check_eq("rst_r_valid",  32'(r_valid),  32'd0);
    check_eq("rst_b_valid",  32'(b_valid),  32'd0);
    check_eq("rst_mem_req",  32'(mem_req),  32'd0);
    check_eq("rst_r_data",   r_data,        32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aw_valid = 1'b0; ar_valid = 1'b0;
    @(posedge clk); #1;

    // INCR write of 4 beats at byte 0x10 -> words 4..7.
    wb = wr_n;
    do_write(32'h10, 8'd3, 3'd2, 4'd5, 32'hA0, -1, bid, bresp);
    check_eq("w1_count", 32'(wr_n - wb), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("w1_addr%0d", k), 32'(wr_addr_log[wb+k]), 32'd4 + 32'(k));
      check_eq($sformatf("w1_data%0d", k), wr_data_log[wb+k], 32'hA0 + 32'(k));
    end
    check_eq("w1_bid",   32'(bid),   32'd5);
    check_eq("w1_bresp", 32'(bresp), 32'd0);

    // Full-throughput read back.
    do_read(32'h10, 8'd3, BURST_INCR, 4'd9, 1'b0);
    check_eq("r1_count",   32'(rd_n), 32'd4);
    check_eq("r1_latency", 32'(first_cyc - hs_cyc), 32'd2);
    check_eq("r1_id",      32'(rd_id0), 32'd9);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("r1_data%0d", k), rd_data[k], 32'hA0 + 32'(k));
      check_eq($sformatf("r1_last%0d", k), 32'(rd_last[k]), 32'(k == 3));
      check_eq($sformatf("r1_cyc%0d", k), 32'(rd_cyc[k] - first_cyc), 32'(k));
    end
    check_eq("r1_resp", 32'(rd_resp[0]), 32'(RESP_OKAY));

    // Back-pressured read: r_ready 1,0,0,1 repeating.
    do_read(32'h10, 8'd3, BURST_INCR, 4'd3, 1'b1);
    check_eq("r2_count", 32'(rd_n), 32'd4);
    check_eq("r2_hold",  32'(hold_bad), 32'd0);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("r2_data%0d", k), rd_data[k], 32'hA0 + 32'(k));

    // Both channels requesting: round-robin starting with read.
    bv0 = both_viol; g = 0;
    aw_addr = 32'h40; aw_len = 8'd0; aw_size = 3'd2; aw_burst = BURST_INCR; aw_id = 4'd1;
    ar_addr = 32'h10; ar_len = 8'd0; ar_size = 3'd2; ar_burst = BURST_INCR; ar_id = 4'd2;
    w_valid = 1'b1; w_data = 32'h55; w_strb = 4'hF; w_last = 1'b1;
    b_ready = 1'b1; r_ready = 1'b1;
    aw_valid = 1'b1; ar_valid = 1'b1;
    for (int t = 0; t < 80 && g < 4; t++) begin
      @(negedge clk);
      if (aw_ready)      begin grant[g] = 1; g++; end
      else if (ar_ready) begin grant[g] = 0; g++; end
    end
    @(posedge clk); #1;
    aw_valid = 1'b0; ar_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    check_eq("arb_grants", 32'(g), 32'd4);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("arb_grant%0d", k), 32'(grant[k]), 32'(k % 2));
    check_eq("arb_both_ready", 32'(both_viol - bv0), 32'd0);

    // FIXED read repeats the same word.
    do_read(32'h14, 8'd1, BURST_FIXED, 4'd2, 1'b0);
    check_eq("fix_count", 32'(rd_n), 32'd2);
    check_eq("fix_data0", rd_data[0], 32'hA1);
    check_eq("fix_data1", rd_data[1], 32'hA1);

    // INCR wraps at the top of the SRAM; upper address bits alias.
    wb = wr_n;
    do_write(32'h7FFC, 8'd1, 3'd2, 4'd3, 32'hB0, -1, bid, bresp);
    check_eq("wrap_count", 32'(wr_n - wb), 32'd2);
    check_eq("wrap_addr0", 32'(wr_addr_log[wb]),   32'hFFF);
    check_eq("wrap_addr1", 32'(wr_addr_log[wb+1]), 32'h000);
    check_eq("wrap_bresp", 32'(bresp), 32'd0);

    // Halfword size is an error: no SRAM access, SLVERR.
    mb = memreq_n;
    do_write(32'h20, 8'd1, 3'd1, 4'd6, 32'hC0, -1, bid, bresp);
    check_eq("sz1_memreq", 32'(memreq_n - mb), 32'd0);
    check_eq("sz1_bresp",  32'(bresp), 32'(RESP_SLVERR));
    check_eq("sz1_bid",    32'(bid), 32'd6);

    // Early w_last: all 3 beats still consumed, SLVERR.
    hb = whs_n;
    do_write(32'h30, 8'd2, 3'd2, 4'd7, 32'hD0, 1, bid, bresp);
    check_eq("wl_beats", 32'(whs_n - hb), 32'd3);
    check_eq("wl_bresp", 32'(bresp), 32'(RESP_SLVERR));

    // Reset in the middle of a stalled read burst.
    r_ready = 1'b0;
    send_ar(32'h10, 8'd3, BURST_INCR, 4'd9);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_r_valid_in", 32'(r_valid), 32'd0);
    check_eq("mrst_mem_req",    32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_r_valid_after", 32'(r_valid), 32'd0);
    check_eq("mrst_b_valid",       32'(b_valid), 32'd0);
    @(posedge clk); #1;
    do_read(32'h18, 8'd1, BURST_INCR, 4'hA, 1'b0);
    check_eq("mrst_count", 32'(rd_n), 32'd2);
    check_eq("mrst_data0", rd_data[0], 32'hA2);
    check_eq("mrst_data1", rd_data[1], 32'hA3);
    check_eq("mrst_last1", 32'(rd_last[1]), 32'd1);
    check_eq("mrst_id",    32'(rd_id0), 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
